// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative signed multiply/divide unit holding the architectural HI/LO
// registers. One radix-2 step is performed per clock, so an operation keeps
// `busy` high for WIDTH+1 cycles (WIDTH iteration steps plus one sign-fix
// and write-back cycle). HI/LO are only written in the final cycle, so
// reads of HI/LO issued while the unit is busy still see the previous
// results.
//
// Ports:
//   clk     - sole clock, rising edge
//   reset   - synchronous, active-high; aborts any operation in flight
//   start   - one-cycle request to begin an operation (ignored while busy)
//   op_div  - 0 = signed multiply, 1 = signed divide (sampled with start)
//   rs_val  - multiplicand / dividend, signed (sampled with start)
//   rt_val  - multiplier / divisor, signed (sampled with start)
//   busy    - registered, high while an operation is in flight
//   done    - registered, one-cycle pulse when HI/LO have just been updated
//   hi      - HI register: product upper half or remainder
//   lo      - LO register: product lower half or quotient
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operation context captured at start.
  logic             op_div_q, op_div_d;
  logic             neg_quo_q, neg_quo_d;    // product / quotient sign
  logic             neg_rem_q, neg_rem_d;    // remainder sign (dividend sign)
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] rs_raw_q, rs_raw_d;      // raw dividend for divide-by-zero HI
  logic [CW-1:0]    cnt_q, cnt_d;

  // |rs| for multiply, |rt| for divide: the operand added / subtracted each step.
  logic [WIDTH-1:0] opnd_q, opnd_d;

  // Multiply accumulator: upper half collects partial sums, lower half
  // initially holds the multiplier and is shifted out LSB first.
  logic [2*WIDTH-1:0] prod_q, prod_d;

  // Divide state: running remainder and quotient. The quotient register
  // starts out holding the dividend, which is shifted out MSB first as
  // quotient bits are shifted in at the bottom.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;

  // Architectural results and registered handshake outputs.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Step datapath signals.
  logic [WIDTH:0]     mult_addend;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  // Unsigned magnitude of a two's complement value. The most negative value
  // maps onto itself, which is exactly its magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  // State and datapath registers. Reset returns the unit to IDLE with
  // HI/LO cleared and wins over a simultaneous start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      rs_raw_q   <= '0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_div_q   <= op_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      rs_raw_q   <= rs_raw_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. RUN lasts exactly WIDTH cycles: the counter is loaded
  // with WIDTH-1 and the step taken while it reads zero is the last one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered handshake outputs. busy follows the next state so it rises
  // on the accepting edge and falls on the write-back edge, the same edge
  // on which done rises; the two are therefore never high together.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX);
  end

  // One shift-add multiply step: conditionally add the multiplicand into
  // the upper half, then shift the whole accumulator right by one. The
  // extra top bit of the sum carries into the shifted-in position.
  always_comb begin
    mult_addend = prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}};
    mult_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + mult_addend;
  end

  // One restoring-divide step. The shifted partial remainder needs WIDTH+1
  // bits; when it is not smaller than the divisor the true difference is
  // below the divisor and so fits in WIDTH bits.
  always_comb begin
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  end

  // Sign-corrected product for the write-back cycle.
  always_comb begin
    prod_fix = neg_quo_q ? (~prod_q + 1'b1) : prod_q;
  end

  // Datapath register updates: operand capture in IDLE, iteration in RUN,
  // HI/LO write-back in FIX. Everything holds its value otherwise.
  always_comb begin
    op_div_d   = op_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    rs_raw_d   = rs_raw_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_div_d   = op_div;
          neg_quo_d  = rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
          neg_rem_d  = rs_val[WIDTH-1];
          div_zero_d = (rt_val == '0);
          rs_raw_d   = rs_val;
          cnt_d      = CNT_LOAD;
          if (op_div) begin
            opnd_d = mag(rt_val);
            rem_d  = '0;
            quo_d  = mag(rs_val);
          end else begin
            opnd_d = mag(rs_val);
            prod_d = {{WIDTH{1'b0}}, mag(rt_val)};
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (op_div_q) begin
          rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], div_ge};
        end else begin
          prod_d = {mult_sum, prod_q[WIDTH-1:1]};
        end
      end

      FIX: begin
        if (!op_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
          // Divide by zero: all-ones quotient, dividend passed through as
          // the remainder with no sign correction.
          hi_d = rs_raw_q;
          lo_d = '1;
        end else begin
          // INT_MIN / -1 needs no special case: the magnitude quotient
          // 0x80..0 negates back to itself.
          hi_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
          lo_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        end
      end

      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed self-checking bench for muldiv_unit. Each operation is issued
// through applyStimulus, then followed cycle by cycle until done, checking
// latency, HI/LO results, that HI/LO hold their old values while busy, and
// that done is a single-cycle pulse. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 33;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int compared   = 0;
  int mismatched = 0;

  // Values HI/LO are expected to hold between operations.
  logic [WIDTH-1:0] prev_hi;
  logic [WIDTH-1:0] prev_lo;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_div (op_div),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one start request for a single cycle. Returns on the falling
  // edge right after the accepting rising edge.
  task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op_div = op;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Issue an operation and follow it to completion. poke1/poke2 give the
  // edge offsets (relative to the accepting edge) at which a stray start
  // with different operands is presented; 0 disables a poke.
  task automatic runOp(input string tag, input logic op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input int poke1, input int poke2);
    int   k;
    int   busy_cycles;
    logic held;
    k           = 0;
    busy_cycles = 0;
    held        = 1'b1;
    applyStimulus(op, a, b);
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) busy_cycles++;
      if (hi !== prev_hi || lo !== prev_lo) held = 1'b0;
      if (k == poke1 - 1 || k == poke2 - 1) begin
        start  = 1'b1;
        op_div = ~op;
        rs_val = 32'h0000_0009;
        rt_val = 32'h0000_0007;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checkOutput({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_latency"}, k, LATENCY);
    checkOutput({tag, "_busy_cycles"}, busy_cycles, LATENCY);
    checkOutput({tag, "_hold"}, {31'b0, held}, 32'd1);
    checkOutput({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_hi"}, hi, exp_hi);
    checkOutput({tag, "_lo"}, lo, exp_lo);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    int done_pulses;
    reset  = 1'b1;
    start  = 1'b0;
    op_div = 1'b0;
    rs_val = '0;
    rt_val = '0;
    prev_hi = '0;
    prev_lo = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);

    // start coinciding with reset must be dropped.
    start  = 1'b1;
    op_div = 1'b0;
    rs_val = 32'd2;
    rt_val = 32'd3;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("reset_start_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("reset_start_busy2", {31'b0, busy}, 32'd0);

    runOp("mul_7_m3",     1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
    runOp("mul_min_min",  1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
    runOp("mul_m1_m1",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 0);
    runOp("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    runOp("div_7_m2",     1'b1, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0);
    runOp("div_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);
    runOp("div_by_zero",  1'b1, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 0, 0);
    runOp("mul_start_ign", 1'b0, 32'd5,       32'd6,        32'h0000_0000, 32'd30,        5, 20);

    // Reset in the middle of a divide: asserted so it is sampled at edge N+10.
    applyStimulus(1'b1, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    done_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_pulses++;
    end
    checkOutput("abort_no_done", done_pulses, 32'd0);
    prev_hi = '0;
    prev_lo = '0;
    runOp("mul_3_4_after_abort", 1'b0, 32'd3, 32'd4, 32'h0000_0000, 32'd12, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative signed multiply/divide unit with architectural HI/LO registers, located in the execute stage directly downstream of the main control decoder. When the decoder recognises `mult`, `div`, `mfhi` or `mflo`, it drives this block. The block performs one radix-2 step per cycle and holds the pipeline through `busy`. It also supplies HI/LO read data for the `mfhi`/`mflo` writeback path.

## Interface
- `WIDTH`, 32: operand and HI/LO width. The iteration count equals `WIDTH`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin an operation. Ignored while `busy`=1.
- `op_div`  in  1  0 = `mult`, 1 = `div`. Sampled with `start`.
- `rs_val`  in  WIDTH  multiplicand or dividend, signed. Sampled with `start`.
- `rt_val`  in  WIDTH  multiplier or divisor, signed. Sampled with `start`.
- `busy`  out  1  operation in flight. The pipeline stalls while this is high.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- The FSM has three states: IDLE, RUN and FIX. Reset puts it in IDLE with `busy`=0, `done`=0, `hi`=0, `lo`=0 and the iteration counter at 0.
- **IDLE.** When `start`=1:
  - Latch `op_div`.
  - Latch |rs| and |rt| as unsigned WIDTH-bit magnitudes. |0x80000000| = 0x80000000.
  - Latch the sign flags `neg_q` = rs[31]^rt[31] and `neg_r` = rs[31].
  - Load the counter with WIDTH-1 and go to RUN.
- **RUN, mult.** Shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
- **RUN, div.** Restoring division, one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits wide so the subtract-and-compare never overflows.
- **RUN counter.** The counter decrements each cycle. After the step at counter = 0, go to FIX.
- **FIX, mult result.** Negate the 2·WIDTH product if `neg_q`. HI = upper half, LO = lower half.
- **FIX, div result.** LO = quotient, negated if `neg_q`. HI = remainder, negated if `neg_r`.
- **FIX, divide by zero** (rt = 0). LO = 0xFFFFFFFF and HI = rs_val unchanged. No sign fix is applied to either.
- **FIX, overflow case.** INT_MIN / -1 gives LO = 0x80000000 and HI = 0. This result comes out of the normal path and needs no special case.
- **FIX, completion.** Write HI/LO, pulse `done`, return to IDLE.
- `hi`/`lo` change only in FIX or on reset. During RUN they keep their previous values, so `mfhi`/`mflo` issued before the stall read the old values.
- `start` while `busy`=1 is ignored: no restart, no operand capture.
- `start` together with `reset` is ignored; reset wins.
- `reset` in RUN or FIX aborts the operation. Next cycle: IDLE, HI=LO=0, `busy`=0, `done`=0.

## Timing
- Let `start` be sampled at edge N.
- `busy` is high after edge N. RUN covers edges N+1 through N+WIDTH.
- FIX registers the result at edge N+WIDTH+1. After that edge `hi`/`lo` hold the new values, `done`=1 for exactly one cycle, and `busy`=0.
- `busy` is therefore high for WIDTH+1 cycles, which is 33 at the default width.
- Back-to-back operation is allowed: a `start` in the cycle where `done`=1 is accepted.
- `busy` and `done` are both registered outputs. They are never high in the same cycle.

## Test plan
- **mult 7 × -3.** At edge N+33: HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` pulses once, `busy` was high for exactly 33 cycles.
- **mult 0x80000000 × 0x80000000.** HI=0x40000000, LO=0x00000000. **mult 0xFFFFFFFF × 0xFFFFFFFF** (-1 × -1): HI=0, LO=1.
- **div -7 / 2.** LO=0xFFFFFFFD, HI=0xFFFFFFFF. **div 7 / -2:** LO=0xFFFFFFFD, HI=1. **div INT_MIN / -1:** LO=0x80000000, HI=0.
- **div 0x1234 / 0.** LO=0xFFFFFFFF, HI=0x00001234, same 33-cycle latency.
- **Start ignored while busy.** Start mult 5×6, re-assert `start` with different operands at cycles N+5 and N+20. Required: single `done` at N+33, HI=0, LO=30. HI/LO keep their prior values throughout RUN.
- **Reset mid-operation.** Assert `reset` at cycle N+10 of a div. Required: next cycle `busy`=0, HI=LO=0, no `done`. A subsequent mult 3×4 gives LO=12 at 33 cycles after its start.
